// File: rtl/maze_ram_arbiter_if.sv
// Bus bundle joining the maze RAM arbiter to the VGA renderer, the game logic and the cell RAM.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface maze_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 4
);
  // VGA renderer side
  logic              vga_blank;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;

  // Game logic side
  logic              game_req;
  logic              game_we;
  logic [ADDR_W-1:0] game_addr;
  logic [DATA_W-1:0] game_wdata;
  logic              game_gnt;
  logic              game_rvalid;
  logic [DATA_W-1:0] game_rdata;

  // Single-port cell RAM side
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  vga_blank, vga_req, vga_addr,
    input  game_req, game_we, game_addr, game_wdata,
    input  ram_rdata,
    output vga_gnt, vga_rvalid, vga_rdata,
    output game_gnt, game_rvalid, game_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output vga_blank, vga_req, vga_addr,
    output game_req, game_we, game_addr, game_wdata,
    output ram_rdata,
    input  vga_gnt, vga_rvalid, vga_rdata,
    input  game_gnt, game_rvalid, game_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/maze_ram_arbiter.sv
// Two-requester arbiter for the single-port maze cell RAM with owner-tagged fixed-latency reads.
// Define ARB_STATS_EN to add the starvation / VGA-wait statistics counters.
module maze_ram_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  maze_ram_arbiter_if.slave        bus_io
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]              stat_starve_o,
  output logic [15:0]              stat_vga_wait_o
`endif
);

  // owner: 1 = game, 0 = VGA
  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

  localparam logic [7:0] StarveMax = 8'(STARVE_MAX);

  logic              vga_gnt;
  logic              game_gnt;
  logic              any_gnt;
  logic              starve;
  logic [7:0]        wait_q, wait_d;

  logic              ram_en_q;
  logic              ram_we_q;
  logic              ram_owner_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;

  tag_t              tag_q [RD_LAT];
  tag_t              tag_ret;

  logic              vga_rvalid_q;
  logic              game_rvalid_q;
  logic [DATA_W-1:0] vga_rdata_q;
  logic [DATA_W-1:0] game_rdata_q;

  assign starve  = (wait_q >= StarveMax);
  assign tag_ret = tag_q[RD_LAT-1];

  always_comb begin
    vga_gnt  = 1'b0;
    game_gnt = 1'b0;
    if (rst_ni) begin
      if (bus_io.game_req && (bus_io.vga_blank || starve)) begin
        game_gnt = 1'b1;
      end else if (bus_io.vga_req) begin
        vga_gnt = 1'b1;
      end else if (bus_io.game_req) begin
        game_gnt = 1'b1;
      end
    end
  end

  assign any_gnt = vga_gnt | game_gnt;

  always_comb begin
    wait_d = wait_q;
    if (!bus_io.game_req || game_gnt) begin
      wait_d = '0;
    end else if (!starve) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q        <= '0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_owner_q   <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
      vga_rvalid_q  <= 1'b0;
      game_rvalid_q <= 1'b0;
      vga_rdata_q   <= '0;
      game_rdata_q  <= '0;
    end else begin
      wait_q   <= wait_d;
      ram_en_q <= any_gnt;
      ram_we_q <= game_gnt & bus_io.game_we;
      if (any_gnt) begin
        ram_owner_q <= game_gnt;
        ram_addr_q  <= game_gnt ? bus_io.game_addr : bus_io.vga_addr;
      end
      // VGA never writes, so wdata only follows game grants
      if (game_gnt) begin
        ram_wdata_q <= bus_io.game_wdata;
      end

      // Tag travels alongside the RAM access and retires when its data is valid
      tag_q[0] <= tag_t'{valid: ram_en_q & ~ram_we_q, owner: ram_owner_q};
      for (int i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end

      vga_rvalid_q  <= tag_ret.valid & ~tag_ret.owner;
      game_rvalid_q <= tag_ret.valid & tag_ret.owner;
      if (tag_ret.valid && !tag_ret.owner) begin
        vga_rdata_q <= bus_io.ram_rdata;
      end
      if (tag_ret.valid && tag_ret.owner) begin
        game_rdata_q <= bus_io.ram_rdata;
      end
    end
  end

  assign bus_io.vga_gnt     = vga_gnt;
  assign bus_io.game_gnt    = game_gnt;
  assign bus_io.ram_en      = ram_en_q;
  assign bus_io.ram_we      = ram_we_q;
  assign bus_io.ram_addr    = ram_addr_q;
  assign bus_io.ram_wdata   = ram_wdata_q;
  assign bus_io.vga_rvalid  = vga_rvalid_q;
  assign bus_io.vga_rdata   = vga_rdata_q;
  assign bus_io.game_rvalid = game_rvalid_q;
  assign bus_io.game_rdata  = game_rdata_q;

`ifdef ARB_STATS_EN
  logic [15:0] stat_starve_q;
  logic [15:0] stat_vga_wait_q;
  logic        starve_win;

  // With VGA asking in the visible region, only the starvation escape lets game win
  assign starve_win = game_gnt & bus_io.vga_req & ~bus_io.vga_blank;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_starve_q   <= '0;
      stat_vga_wait_q <= '0;
    end else begin
      if (starve_win && stat_starve_q != 16'hFFFF) begin
        stat_starve_q <= stat_starve_q + 16'd1;
      end
      if (bus_io.vga_req && !vga_gnt && stat_vga_wait_q != 16'hFFFF) begin
        stat_vga_wait_q <= stat_vga_wait_q + 16'd1;
      end
    end
  end

  assign stat_starve_o   = stat_starve_q;
  assign stat_vga_wait_o = stat_vga_wait_q;
`endif

endmodule

// File: tb/tb_maze_ram_arbiter.sv
// Self-checking bench for maze_ram_arbiter: directed scenarios followed by random traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_maze_ram_arbiter;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned DATA_W     = 4;
  localparam int unsigned RD_LAT     = 1;
  localparam int unsigned STARVE_MAX = 8;

  typedef struct {
    int unsigned       due;
    bit                owner;
    logic [DATA_W-1:0] data;
  } ret_t;

  logic clk;
  logic rst_n;
  logic mem_clear;

  maze_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ARB_STATS_EN
  logic [15:0] stat_starve;
  logic [15:0] stat_vga_wait;
`endif

  maze_ram_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .RD_LAT    (RD_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .bus_io         (bus)
`ifdef ARB_STATS_EN
    ,
    .stat_starve_o  (stat_starve),
    .stat_vga_wait_o(stat_vga_wait)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    return ~a[3:0] ^ a[7:4] ^ {2'b00, a[9:8]};
  endfunction

  // Cell RAM with RD_LAT cycles from strobe to data
  logic [DATA_W-1:0] mem     [2**ADDR_W];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= init_val(ADDR_W'(i));
    end else if (bus.ram_en && bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    if (bus.ram_en && !bus.ram_we) rd_pipe[0] <= mem[bus.ram_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign bus.ram_rdata = rd_pipe[RD_LAT-1];

  // Reference model state
  int unsigned       n_checks;
  int unsigned       n_fails;
  int unsigned       cyc;
  bit                in_reset;
  int unsigned       wait_m;
  bit                exp_en;
  bit                exp_we;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_wdata;
  logic [DATA_W-1:0] exp_vrd;
  logic [DATA_W-1:0] exp_grd;
  logic [DATA_W-1:0] ref_mem [2**ADDR_W];
  ret_t              ret_q [$];
  int unsigned       m_starve;
  int unsigned       m_vga_wait;
  bit                last_vga_gnt;
  bit                last_game_gnt;
  bit                last_vga_rvalid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    ret_q.delete();
    wait_m     = 0;
    exp_en     = 1'b0;
    exp_we     = 1'b0;
    exp_addr   = '0;
    exp_wdata  = '0;
    exp_vrd    = '0;
    exp_grd    = '0;
    m_starve   = 0;
    m_vga_wait = 0;
  endtask

  // One clock cycle: check outputs at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    bit   eg_game, eg_vga, starving, exp_vrv, exp_grv;
    ret_t r;
    @(negedge clk);
    starving = (wait_m >= STARVE_MAX);
    eg_game  = !in_reset && bus.game_req && (bus.vga_blank || starving || !bus.vga_req);
    eg_vga   = !in_reset && bus.vga_req && !eg_game;
    exp_vrv  = 1'b0;
    exp_grv  = 1'b0;
    if (ret_q.size() != 0 && ret_q[0].due == cyc) begin
      r = ret_q.pop_front();
      if (r.owner) begin
        exp_grv = 1'b1;
        exp_grd = r.data;
      end else begin
        exp_vrv = 1'b1;
        exp_vrd = r.data;
      end
    end
    chk("vga_gnt", bus.vga_gnt, eg_vga);
    chk("game_gnt", bus.game_gnt, eg_game);
    chk("ram_en", bus.ram_en, exp_en);
    chk("ram_addr", bus.ram_addr, exp_addr);
    if (exp_en || in_reset) chk("ram_we", bus.ram_we, exp_we);
    if ((exp_en && exp_we) || in_reset) chk("ram_wdata", bus.ram_wdata, exp_wdata);
    chk("vga_rvalid", bus.vga_rvalid, exp_vrv);
    chk("game_rvalid", bus.game_rvalid, exp_grv);
    chk("vga_rdata", bus.vga_rdata, exp_vrd);
    chk("game_rdata", bus.game_rdata, exp_grd);
`ifdef ARB_STATS_EN
    chk("stat_starve", stat_starve, m_starve);
    chk("stat_vga_wait", stat_vga_wait, m_vga_wait);
`endif
    last_vga_gnt    = bus.vga_gnt;
    last_game_gnt   = bus.game_gnt;
    last_vga_rvalid = bus.vga_rvalid;
    @(posedge clk);
    if (!in_reset) begin
      if (eg_game) begin
        exp_addr = bus.game_addr;
        if (bus.game_we) begin
          ref_mem[bus.game_addr] = bus.game_wdata;
          exp_wdata = bus.game_wdata;
        end else begin
          r.due   = cyc + RD_LAT + 2;
          r.owner = 1'b1;
          r.data  = ref_mem[bus.game_addr];
          ret_q.push_back(r);
        end
      end else if (eg_vga) begin
        exp_addr = bus.vga_addr;
        r.due    = cyc + RD_LAT + 2;
        r.owner  = 1'b0;
        r.data   = ref_mem[bus.vga_addr];
        ret_q.push_back(r);
      end
      exp_en = eg_game || eg_vga;
      exp_we = eg_game && bus.game_we;
      if (bus.game_req && !eg_game) wait_m = (wait_m < STARVE_MAX) ? wait_m + 1 : wait_m;
      else wait_m = 0;
      if (eg_game && bus.vga_req && !bus.vga_blank && m_starve < 16'hFFFF) m_starve++;
      if (bus.vga_req && !eg_vga && m_vga_wait < 16'hFFFF) m_vga_wait++;
    end
    cyc++;
    #1;
  endtask

  int unsigned rv_seen;

  initial begin
    n_checks        = 0;
    n_fails         = 0;
    cyc             = 0;
    last_vga_gnt    = 1'b0;
    last_game_gnt   = 1'b0;
    last_vga_rvalid = 1'b0;
    rst_n           = 1'b0;
    in_reset        = 1'b1;
    mem_clear       = 1'b1;
    bus.vga_blank   = 1'b0;
    bus.vga_req     = 1'b1;
    bus.vga_addr    = '0;
    bus.game_req    = 1'b1;
    bus.game_we     = 1'b0;
    bus.game_addr   = '0;
    bus.game_wdata  = '0;
    for (int i = 0; i < 2**ADDR_W; i++) ref_mem[i] = init_val(ADDR_W'(i));
    model_reset();

    // Reset held 5 cycles with both requests up: grants must stay low
    cycle();
    mem_clear = 1'b0;
    repeat (4) cycle();
    bus.vga_req  = 1'b0;
    bus.game_req = 1'b0;
    rst_n        = 1'b1;
    in_reset     = 1'b0;
    repeat (20) cycle();

    // Single VGA read of cell 0x005
    bus.vga_addr = 10'h005;
    bus.vga_req  = 1'b1;
    cycle();
    chk("vga_single_gnt", last_vga_gnt, 1'b1);
    bus.vga_req = 1'b0;
    rv_seen = 0;
    repeat (4) begin
      cycle();
      rv_seen += last_vga_rvalid;
    end
    chk("vga_single_rdata", bus.vga_rdata, 4'hA);
    chk("vga_single_pulses", rv_seen, 1);

    // Contention in the visible region: 8 VGA grants, then game, then VGA
    bus.vga_blank = 1'b0;
    bus.vga_req   = 1'b1;
    bus.game_req  = 1'b1;
    bus.game_we   = 1'b0;
    bus.game_addr = 10'h042;
    for (int k = 0; k < 10; k++) begin
      bus.vga_addr = ADDR_W'(k + 16);
      cycle();
      chk("contention_game_gnt", last_game_gnt, k == 8);
      chk("contention_vga_gnt", last_vga_gnt, k != 8);
    end
    bus.vga_req  = 1'b0;
    bus.game_req = 1'b0;
    repeat (4) cycle();

    // Blanking: game wins every cycle
    bus.vga_blank = 1'b1;
    bus.vga_req   = 1'b1;
    bus.game_req  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.game_addr = ADDR_W'(k + 32);
      cycle();
      chk("blank_game_gnt", last_game_gnt, 1'b1);
      chk("blank_vga_gnt", last_vga_gnt, 1'b0);
    end
    bus.vga_req   = 1'b0;
    bus.game_req  = 1'b0;
    bus.vga_blank = 1'b0;
    repeat (4) cycle();

    // Game write then back-to-back read of the same cell
    bus.game_req   = 1'b1;
    bus.game_we    = 1'b1;
    bus.game_addr  = 10'h100;
    bus.game_wdata = 4'h7;
    cycle();
    bus.game_we = 1'b0;
    cycle();
    bus.game_req = 1'b0;
    repeat (4) cycle();
    chk("wr_rd_data", bus.game_rdata, 4'h7);

    // Random traffic honouring the hold-until-grant handshake
    for (int k = 0; k < 400; k++) begin
      bus.vga_blank = ((k % 60) >= 45);
      if (last_vga_gnt || !bus.vga_req) begin
        bus.vga_req  = ($urandom_range(0, 3) != 0);
        bus.vga_addr = ADDR_W'($urandom_range(0, 767));
      end else if ($urandom_range(0, 15) == 0) begin
        bus.vga_req = 1'b0;
      end
      if (last_game_gnt || !bus.game_req) begin
        bus.game_req   = ($urandom_range(0, 2) != 0);
        bus.game_we    = ($urandom_range(0, 2) == 0);
        bus.game_addr  = ADDR_W'($urandom_range(0, 15));
        bus.game_wdata = DATA_W'($urandom_range(0, 15));
      end else if ($urandom_range(0, 15) == 0) begin
        bus.game_req = 1'b0;
      end
      cycle();
    end
    bus.vga_req  = 1'b0;
    bus.game_req = 1'b0;
    repeat (5) cycle();

    // Reset one cycle after a VGA read grant drops that read
    bus.vga_blank = 1'b0;
    bus.vga_addr  = 10'h01F;
    bus.vga_req   = 1'b1;
    cycle();
    chk("midrst_gnt", last_vga_gnt, 1'b1);
    bus.vga_req = 1'b0;
    rst_n       = 1'b0;
    in_reset    = 1'b1;
    model_reset();
    repeat (2) cycle();
    rst_n    = 1'b1;
    in_reset = 1'b0;
    rv_seen  = 0;
    repeat (10) begin
      cycle();
      rv_seen += last_vga_rvalid;
    end
    chk("midrst_no_rvalid", rv_seen, 0);
`ifdef ARB_STATS_EN
    chk("midrst_stat_starve", stat_starve, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
